// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite ROM arbiter and its round-robin picker.
package sprite_pkg;

    localparam int SPRITE_ADDR_W = 10;
    localparam int SPRITE_IDX_W  = 3;

    // Tag id is sized for the largest supported requester count (8).
    localparam int MAX_REQ  = 8;
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } rom_tag_t;

    function automatic logic [TAG_ID_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [TAG_ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx |= TAG_ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, wrapping.
module rr_pick
    import sprite_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] winner
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[(int'(rr_ptr) + i) % N_REQ]) begin
                grant[(int'(rr_ptr) + i) % N_REQ] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign winner = IDX_W'(onehot_to_idx(MAX_REQ'(grant)));

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM read port among N_REQ requesters; tags each read so the
// returned palette index is routed back to its owner with a one-hot valid.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ADDR_W      = SPRITE_ADDR_W,
    parameter int DATA_W      = SPRITE_IDX_W,
    parameter int ROM_LATENCY = 1
) (
    input  logic                    vga_clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        grant,
    output logic [ADDR_W-1:0]       rom_address,
    input  logic [DATA_W-1:0]       rom_q,
    output logic [DATA_W-1:0]       rdata,
    output logic [N_REQ-1:0]        rvalid,
    output logic                    busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic             xfer;
    logic             busy_next;
    rom_tag_t         new_tag;
    rom_tag_t         out_tag;
    rom_tag_t         tag_pipe [ROM_LATENCY];

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .winner (winner)
    );

    assign xfer    = |(req & grant);
    assign out_tag = tag_pipe[ROM_LATENCY-1];

    always_comb begin
        new_tag       = '0;
        new_tag.valid = xfer;
        new_tag.id    = TAG_ID_W'(winner);
    end

    // busy reflects the pipeline contents after this edge: the incoming tag plus
    // every stage except the one being retired.
    always_comb begin
        busy_next = xfer;
        for (int i = 0; i < ROM_LATENCY - 1; i++) begin
            busy_next = busy_next | tag_pipe[i].valid;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            rom_address <= '0;
            rdata       <= '0;
            rvalid      <= '0;
            busy        <= 1'b0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            if (xfer) begin
                rom_address <= addr[int'(winner)*ADDR_W +: ADDR_W];
                rr_ptr      <= (winner == IDX_W'(N_REQ-1)) ? '0 : winner + 1'b1;
            end
            tag_pipe[0] <= new_tag;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (out_tag.valid) begin
                rdata  <= rom_q;
                rvalid <= N_REQ'(1) << out_tag.id;
            end else begin
                rvalid <= '0;
            end
            busy <= busy_next;
        end
    end

endmodule
